// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: default widths, reset vector, NOP encoding, FSM states.
package riscv_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    HOLD,
    DRAIN,
    TRAP
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect decode and next-PC candidates; jump outranks a taken branch.
// Optional PC_MISALIGN_TRAP_EN reports misaligned targets instead of masking them.
module pc_next_sel
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            take_branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            target_misaligned_o,
`endif
  output logic [XLEN-1:0] pc_inc_o
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    redirect_o = jump_i | take_branch_i;
    raw_target = jump_i ? jump_target_i : branch_target_i;
    pc_inc_o   = pc_i + XLEN'(4);
`ifdef PC_MISALIGN_TRAP_EN
    target_o            = raw_target;
    target_misaligned_o = (raw_target[1:0] != 2'b00);
`else
    target_o = raw_target & ~XLEN'(3);
`endif
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: owns the PC, runs the imem req/ack handshake, feeds decode through
// an output register plus one-entry skid. Optional trap on misaligned targets: PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            take_branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr,
`endif
  output logic            flush
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, target_q, target_d;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [31:0]     out_instr_q, out_instr_d, skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
  logic            flush_q, flush_d;
  logic            redirect, consume, ack;
  logic [XLEN-1:0] target, pc_inc;
`ifdef PC_MISALIGN_TRAP_EN
  logic            tgt_mis, mis_q, mis_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
`endif

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc_i            (pc_q),
    .take_branch_i   (take_branch),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .redirect_o      (redirect),
    .target_o        (target),
`ifdef PC_MISALIGN_TRAP_EN
    .target_misaligned_o (tgt_mis),
`endif
    .pc_inc_o        (pc_inc)
  );

  assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr   = pc_q;
  assign ack         = imem_req & imem_ack;
  assign consume     = out_valid_q & ~stall;
  assign instr_valid = out_valid_q;
  assign instr       = out_instr_q;
  assign instr_pc    = out_pc_q;
  assign flush       = flush_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned  = mis_q;
  assign bad_addr    = bad_addr_q;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    out_valid_d  = out_valid_q & ~consume;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    flush_d      = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    mis_d        = 1'b0;
    bad_addr_d   = bad_addr_q;
`endif

    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (ack && !redirect) begin
          pc_d = pc_inc;
          if (!out_valid_q || consume) begin
            out_valid_d = 1'b1;
            out_instr_d = imem_rdata;
            out_pc_d    = pc_q;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end else if (ack) begin
          pc_d = target;
        end else if (redirect) begin
          target_d = target;
          state_d  = DRAIN;
        end
      end
      HOLD: begin
        if (consume) begin
          out_valid_d  = 1'b1;
          out_instr_d  = skid_instr_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      DRAIN: begin
        if (ack) begin
          pc_d    = redirect ? target : target_q;
          state_d = REQ;
        end else if (redirect) begin
          target_d = target;
        end
      end
      default: ;
    endcase

    // Redirect overrides whatever the state logic loaded: kill output and skid.
    if (redirect && state_q != TRAP) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      flush_d      = 1'b1;
      if (state_q == BOOT || state_q == HOLD) begin
        pc_d    = target;
        state_d = REQ;
      end
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt_mis) begin
        flush_d    = 1'b0;
        pc_d       = pc_q;
        target_d   = target_q;
        state_d    = TRAP;
        mis_d      = 1'b1;
        bad_addr_d = target;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      target_q     <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      flush_q      <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      mis_q        <= 1'b0;
      bad_addr_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      flush_q      <= flush_d;
`ifdef PC_MISALIGN_TRAP_EN
      mis_q        <= mis_d;
      bad_addr_q   <= bad_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios then random traffic, checked against a
// queue-based fetch model. Honours PC_MISALIGN_TRAP_EN when defined.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, take_branch, jump, stall, imem_ack;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, instr_valid, flush;
  logic [31:0] imem_addr, instr, instr_pc;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misaligned;
  logic [31:0] bad_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk           (clk),
    .rst           (rst),
    .take_branch   (take_branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
`ifdef PC_MISALIGN_TRAP_EN
    .misaligned    (misaligned),
    .bad_addr      (bad_addr),
`endif
    .flush         (flush)
  );

  // Model: up to two delivered instructions wait in a queue; fetch requests whenever
  // there is room, or while an abandoned request is still being drained.
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_pend, m_bad;
  bit          m_boot, m_drain, m_trap, m_flush, m_mis;

  function automatic bit m_req();
    return !m_boot && !m_trap && (m_drain || mq.size() < 2);
  endfunction

  task automatic model_step();
    bit          redir, req, cons, xfer, bad;
    logic [31:0] tgt;
    if (rst) begin
      mq.delete();
      m_pc = RV; m_pend = '0; m_bad = '0;
      m_boot = 1'b1; m_drain = 1'b0; m_trap = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
      return;
    end
    redir = jump || take_branch;
    tgt   = jump ? jump_target : branch_target;
    bad   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    bad = (tgt[1:0] != 2'b00);
`else
    tgt[1:0] = 2'b00;
`endif
    req  = m_req();
    cons = (mq.size() > 0) && !stall;
    xfer = req && imem_ack;
    m_flush = 1'b0;
    m_mis   = 1'b0;
    if (m_trap) begin
      m_trap = 1'b1;
    end else if (redir && bad) begin
      m_trap = 1'b1; m_mis = 1'b1; m_bad = tgt; m_drain = 1'b0;
      mq.delete();
    end else if (redir) begin
      m_flush = 1'b1;
      mq.delete();
      if (m_drain) begin
        if (xfer) begin m_pc = tgt; m_drain = 1'b0; end
        else m_pend = tgt;
      end else if (req && !xfer) begin
        m_drain = 1'b1; m_pend = tgt;
      end else begin
        m_pc = tgt;
      end
    end else begin
      if (cons) void'(mq.pop_front());
      if (m_drain) begin
        if (xfer) begin m_pc = m_pend; m_drain = 1'b0; end
      end else if (xfer) begin
        mq.push_back({m_pc ^ SALT, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    m_boot = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
    if (m_req()) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("instr", instr, mq[0].ins);
      chk("instr_pc", instr_pc, mq[0].pc);
    end
    chk("flush", {31'b0, flush}, {31'b0, m_flush});
`ifdef PC_MISALIGN_TRAP_EN
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    chk("bad_addr", bad_addr, m_bad);
`endif
  endtask

  // Inputs are set at edge+1; memory answers with addr^SALT when acking.
  task automatic cyc();
    imem_rdata = imem_ack ? (imem_addr ^ SALT) : $urandom();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; take_branch = 1'b0; jump = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    branch_target = '0; jump_target = '0; imem_rdata = '0;

    // reset for two cycles with a stray ack present
    cyc(); cyc();
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'h0);
    rst = 1'b0;

    // streaming, then stall backpressure and release
    repeat (8) cyc();
    stall = 1'b1; repeat (4) cyc();
    stall = 1'b0; repeat (4) cyc();

    // taken branch
    take_branch = 1'b1; branch_target = 32'h100; cyc(); take_branch = 1'b0;
    chk("br_flush", {31'b0, flush}, 32'd1);
    chk("br_addr", imem_addr, 32'h100);
    repeat (3) cyc();

    // two redirects while a fetch is outstanding
    imem_ack = 1'b0; cyc();
    jump = 1'b1; jump_target = 32'h200; cyc(); jump = 1'b0;
    take_branch = 1'b1; branch_target = 32'h300; cyc(); take_branch = 1'b0;
    imem_ack = 1'b1; cyc();
    chk("drain_addr", imem_addr, 32'h300);
    repeat (3) cyc();

    // jump beats branch
    jump = 1'b1; jump_target = 32'h40; take_branch = 1'b1; branch_target = 32'h80;
    cyc();
    jump = 1'b0; take_branch = 1'b0;
    chk("jump_prio", imem_addr, 32'h40);
    repeat (3) cyc();

    // PC wrap
    jump = 1'b1; jump_target = 32'hFFFF_FFF8; cyc(); jump = 1'b0;
    repeat (5) cyc();

    // misaligned target
    take_branch = 1'b1; branch_target = 32'h102; cyc(); take_branch = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'b0, misaligned}, 32'd1);
    chk("mis_bad_addr", bad_addr, 32'h102);
    repeat (4) cyc();
    chk("trap_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1; cyc(); rst = 1'b0;
`else
    chk("mis_addr", imem_addr, 32'h100);
`endif
    repeat (3) cyc();

    // random traffic, including one reset mid-transfer
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      r = $urandom_range(0, 15);
      jump          = (r == 0) || (r == 3);
      take_branch   = (r == 1) || (r == 2) || (r == 3);
      jump_target   = $urandom();
      branch_target = $urandom();
`ifdef PC_MISALIGN_TRAP_EN
      jump_target[1:0]   = 2'b00;
      branch_target[1:0] = 2'b00;
`endif
      imem_ack = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 2) == 0);
      rst      = (i == 700);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage controller that owns the program counter and consumes the `takeBranch` decision from the branch-compare logic, plus the jump request from decode.
- Issues word fetches to instruction memory over a req/ack handshake and presents the returned instructions to decode through a registered output with a one-entry skid buffer.
- Kills the wrong-path fetch on every redirect; a redirect is a taken branch or a jump.

Parameters:
- XLEN, 32, address/data width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- take_branch  in  1  branch-compare result for the instruction in execute.
- branch_target  in  XLEN  target address when `take_branch=1`.
- jump  in  1  JAL/JALR redirect request.
- jump_target  in  XLEN  target address when `jump=1`.
- stall  in  1  decode not accepting this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; stable while `imem_req=1`.
- imem_ack  in  1  request completes this cycle; `imem_rdata` is valid.
- imem_rdata  in  32  fetched instruction.
- instr_valid  out  1  `instr`/`instr_pc` hold a valid instruction.
- instr  out  32  instruction to decode.
- instr_pc  out  XLEN  PC of `instr`.
- flush  out  1  one-cycle pulse: decode must drop its current instruction.

Behaviour:
- Reset (`rst=1` at an edge, overrides everything):
  - Outputs: `pc=RESET_VECTOR`, `state=BOOT`, `imem_req=0`, `instr_valid=0`, `instr=32'h0000_0013` (NOP), `instr_pc=0`, `flush=0`.
  - Skid buffer cleared.
  - Reset mid-transfer abandons the outstanding request; a late `imem_ack` after reset is ignored while in BOOT.
- Redirect:
  - `redirect = jump | take_branch`.
  - Target = `jump_target` if `jump=1`, else `branch_target`; `jump` has priority.
- Handshake:
  - Transfer occurs when `imem_req & imem_ack`.
  - `imem_req` stays high and `imem_addr` stays stable until ack.
  - An ack in the same cycle the request is raised is legal.
- Consume: the output is consumed when `instr_valid & ~stall`.
- State BOOT:
  - `imem_req=0`.
  - Next state REQ after one cycle.
- State REQ:
  - `imem_req=1`, `imem_addr=pc`.
  - Ack and no redirect:
    - `pc<=pc+4` (mod 2^XLEN; wrap from FFFF_FFFC to 0 is silent).
    - Data goes to the output register if it is empty or being consumed; `instr_valid=1` at N+1 for an ack at N.
    - Otherwise data goes to the skid buffer and state goes to HOLD.
  - Ack and redirect: data discarded, `pc<=target`, stay in REQ.
  - No ack and redirect: `target_q<=target`, next state DRAIN.
- State HOLD:
  - `imem_req=0`.
  - When the output is consumed: skid moves to output, next state REQ.
  - On redirect: skid cleared, `pc<=target`, next state REQ.
- State DRAIN:
  - `imem_req=1` at the old address until ack; ack data discarded.
  - A new redirect in DRAIN overwrites `target_q`.
  - On ack: `pc<=target_q` (or the new target if a redirect arrives in the same cycle), next state REQ.
- Flush on any redirect, registered:
  - `flush=1` for exactly one cycle.
  - `instr_valid<=0` and the skid buffer is cleared the same edge.
  - Stall does not block a redirect.
- Simultaneous redirect and consume: the redirect wins; nothing from the wrong path is ever presented.
- Throughput: one instruction per cycle when `imem_ack` is tied high and `stall=0`.

Optional Feature:
- Macro: `PC_MISALIGN_TRAP_EN`.
- Defined:
  - Adds output `misaligned` (1 bit) and output `bad_addr` (XLEN).
  - A redirect whose target has `[1:0]!=2'b00` is not taken; instead `misaligned` pulses one cycle and `bad_addr` latches the target.
  - Fetch then stops in a TRAP state until reset.
- Undefined: target bits `[1:0]` are forced to 0 and there is no TRAP state.

Decomposition:
- Package `riscv_pkg`: XLEN, RESET_VECTOR default, NOP encoding 32'h0000_0013, and the `fetch_state_t` enum {BOOT, REQ, HOLD, DRAIN, TRAP}.
- One combinational sub-module `pc_next_sel`: computes next PC from pc, `pc+4`, redirect targets and the priority rule.

Test Plan:
- Reset vector and streaming:
  - Stimulus: `rst` high for 2 cycles, `imem_ack` tied 1, instruction memory returns `addr^32'hA5A5_0000`, `stall=0`.
  - Response: `imem_addr` sequence 0,4,8,C; `instr_valid` from cycle 2; `instr_pc` trails `imem_addr` by one cycle.
- Stall backpressure:
  - Stimulus: `stall=1` for 4 cycles while streaming.
  - Response: at most 2 instructions buffered, `imem_req=0` in HOLD, no loss or duplication; after release, `instr_pc` continues 8, C, 10.
- Taken branch:
  - Stimulus: `take_branch=1`, `branch_target=32'h100` for one cycle.
  - Response: `flush=1` next cycle, `instr_valid=0`, next `imem_addr=100`, first post-flush `instr_pc=100`.
- Redirect during an outstanding fetch:
  - Stimulus: ack delayed 3 cycles, `jump=1` to 200 at cycle 1, `take_branch=1` to 300 at cycle 2.
  - Response: old data dropped; next request at 300.
- Jump beats branch:
  - Stimulus: `jump=1` to 40 and `take_branch=1` to 80 in the same cycle.
  - Response: next PC is 40.
- Misaligned target, with `PC_MISALIGN_TRAP_EN` defined:
  - Stimulus: `branch_target=32'h102`.
  - Response: `misaligned` pulses, `bad_addr=102`, `imem_req` stays 0 until reset.
- Same stimulus with `PC_MISALIGN_TRAP_EN` undefined:
  - Response: fetch proceeds at 100.
